// File: rtl/sevenseg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sevenseg_pkg                                                       |
// | Segment glyph constants, blank code and seg_t for the scan driver. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sevenseg_pkg;

  // Bit order {a,b,c,d,e,f,g}, a is the MSB.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage : sevenseg_pkg
`default_nettype wire

// File: rtl/sevenseg_scan_driver_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sevenseg_scan_driver_if                                            |
// | Control/display bundle between score logic and the scan driver.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface sevenseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en_i;
  logic                    load_i;
  logic [4*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]   blank_i;
  logic                    lz_i;
  logic [NUM_DIGITS-1:0]   blink_i;
  logic [6:0]              seg_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic                    frame_o;
  logic                    pending_o;

  modport master (
    output en_i, load_i, digits_i, blank_i, lz_i, blink_i,
    input  seg_o, an_o, frame_o, pending_o
  );

  modport slave (
    input  en_i, load_i, digits_i, blank_i, lz_i, blink_i,
    output seg_o, an_o, frame_o, pending_o
  );
endinterface : sevenseg_scan_driver_if
`default_nettype wire

// File: rtl/sevenseg_glyph_rom.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sevenseg_glyph_rom                                                 |
// | Combinational digit code to segment glyph with forced blank.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sevenseg_glyph_rom
  import sevenseg_pkg::*;
#(
  parameter int HEX_EN = 0
) (
  input  wire logic [3:0] code,
  input  wire logic       blank,
  output seg_t            seg
);

  localparam bit HEX_ON = (HEX_EN != 0);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (code)
        4'h0:    seg = SEG_0;
        4'h1:    seg = SEG_1;
        4'h2:    seg = SEG_2;
        4'h3:    seg = SEG_3;
        4'h4:    seg = SEG_4;
        4'h5:    seg = SEG_5;
        4'h6:    seg = SEG_6;
        4'h7:    seg = SEG_7;
        4'h8:    seg = SEG_8;
        4'h9:    seg = SEG_9;
        4'hA:    seg = HEX_ON ? SEG_A : SEG_BLANK;
        4'hB:    seg = HEX_ON ? SEG_B : SEG_BLANK;
        4'hC:    seg = HEX_ON ? SEG_C : SEG_BLANK;
        4'hD:    seg = HEX_ON ? SEG_D : SEG_BLANK;
        4'hE:    seg = HEX_ON ? SEG_E : SEG_BLANK;
        default: seg = HEX_ON ? SEG_F : SEG_BLANK;
      endcase
    end
  end

endmodule : sevenseg_glyph_rom
`default_nettype wire

// File: rtl/sevenseg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sevenseg_scan_driver                                               |
// | Tear-free multiplexed N-digit seven-segment scanner.               |
// | Optional blink: define SEVENSEG_BLINK_EN.                          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024,
  parameter int ACTIVE_LOW = 0,
  parameter int HEX_EN     = 0,
  parameter int BLINK_DIV  = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  sevenseg_scan_driver_if.slave  bus
);

  localparam int                    DIV_W    = $clog2(SCAN_DIV);
  localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t                  SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW != 0}};

  logic [DIV_W-1:0]        r_div;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic                    r_pending;
  logic                    r_frame;
  seg_t                    r_seg;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_tc;
  logic                    w_wrap;
  logic                    w_zero_run;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  logic [3:0]              w_code;
  logic                    w_blank;
  logic                    w_blink_phase;
  seg_t                    w_glyph;

  assign w_tc   = bus.en_i && (r_div == DIV_LAST);
  assign w_wrap = w_tc && (r_idx == IDX_LAST);

  // Walk from the most-significant digit down; a digit is suppressed while
  // it and everything above it are zero. Digit 0 always shows.
  always_comb begin
    w_zero_run = 1'b1;
    w_lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run   = w_zero_run & (r_disp[4*k +: 4] == 4'd0);
      w_lz_mask[k] = bus.lz_i & w_zero_run & (k != 0);
    end
  end

  always_comb begin
    w_code   = BLANK_CODE;
    w_blank  = 1'b0;
    w_an_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_code      = r_disp[4*k +: 4];
        w_blank     = bus.blank_i[k] | w_lz_mask[k] | (w_blink_phase & bus.blink_i[k]);
        w_an_sel[k] = 1'b1;
      end
    end
  end

  sevenseg_glyph_rom #(
    .HEX_EN (HEX_EN)
  ) u_glyph_rom (
    .code  (w_code),
    .blank (w_blank),
    .seg   (w_glyph)
  );

`ifdef SEVENSEG_BLINK_EN
  localparam int               BCNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BLINK_DIV - 1);

  logic [BCNT_W-1:0] r_blink_cnt;
  logic              r_blink_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink_cnt == BCNT_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_blink_phase = r_blink_phase;
`else
  logic w_unused_blink_div;
  assign w_unused_blink_div = (BLINK_DIV != 0);
  assign w_blink_phase      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_idx     <= '0;
      r_pend    <= '0;
      r_disp    <= {NUM_DIGITS{BLANK_CODE}};
      r_pending <= 1'b0;
      r_frame   <= 1'b0;
      r_seg     <= SEG_OFF;
      r_an      <= AN_OFF;
    end else begin
      if (bus.en_i) begin
        if (w_tc) begin
          r_div <= '0;
          r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
        r_frame <= w_wrap;
        r_seg   <= w_glyph ^ SEG_OFF;
        r_an    <= w_an_sel ^ AN_OFF;
      end else begin
        r_div   <= '0;
        r_idx   <= '0;
        r_frame <= 1'b0;
        r_seg   <= SEG_OFF;
        r_an    <= AN_OFF;
      end

      // The display takes the old pending value even if a new load lands
      // in the boundary cycle; that new load then stays pending.
      if (w_wrap && r_pending) begin
        r_disp <= r_pend;
      end
      if (bus.load_i) begin
        r_pend    <= bus.digits_i;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.seg_o     = r_seg;
  assign bus.an_o      = r_an;
  assign bus.frame_o   = r_frame;
  assign bus.pending_o = r_pending;

endmodule : sevenseg_scan_driver
`default_nettype wire

// File: tb/tb_sevenseg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sevenseg_scan_driver                                            |
// | Directed self-checking bench for sevenseg_scan_driver (4 digits).  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sevenseg_scan_driver;

  localparam logic [6:0] G0 = 7'b1111110;
  localparam logic [6:0] G1 = 7'b0110000;
  localparam logic [6:0] G2 = 7'b1101101;
  localparam logic [6:0] G3 = 7'b1111001;
  localparam logic [6:0] G4 = 7'b0110011;
  localparam logic [6:0] G5 = 7'b1011011;
  localparam logic [6:0] G6 = 7'b1011111;
  localparam logic [6:0] G7 = 7'b1110000;
  localparam logic [6:0] G9 = 7'b1111011;
  localparam logic [6:0] BL = 7'b0000000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.NUM_DIGITS(4)) bus ();
  sevenseg_scan_driver_if #(.NUM_DIGITS(4)) bus_al ();

  sevenseg_scan_driver #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .ACTIVE_LOW (0),
    .HEX_EN     (0),
    .BLINK_DIV  (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  sevenseg_scan_driver #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .ACTIVE_LOW (1),
    .HEX_EN     (0),
    .BLINK_DIV  (2)
  ) u_dut_al (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_al)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_frame(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.frame_o && n < 40);
    check({tag, " frame seen"}, {31'd0, bus.frame_o}, 32'd1);
  endtask

  // Starts on a frame_o sample, checks one full frame, ends on the next one.
  task automatic run_frame(input string tag,
                           input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3,
                           input int la, input logic [15:0] va,
                           input int lb, input logic [15:0] vb);
    logic [6:0] exp_seg [4];
    logic [3:0] exp_an;
    exp_seg[0] = e0;
    exp_seg[1] = e1;
    exp_seg[2] = e2;
    exp_seg[3] = e3;
    for (int t = 0; t < 16; t++) begin
      if (t == la) begin
        bus.load_i   = 1'b1;
        bus.digits_i = va;
      end else if (t == lb) begin
        bus.load_i   = 1'b1;
        bus.digits_i = vb;
      end
      tick();
      bus.load_i = 1'b0;
      exp_an = 4'b0001 << (t / 4);
      check({tag, " an"}, {28'd0, bus.an_o}, {28'd0, exp_an});
      check({tag, " seg"}, {25'd0, bus.seg_o}, {25'd0, exp_seg[t / 4]});
      if (t == 7) check({tag, " frame mid"}, {31'd0, bus.frame_o}, 32'd0);
    end
    check({tag, " frame end"}, {31'd0, bus.frame_o}, 32'd1);
  endtask

  initial begin
    bus.en_i = 0; bus.load_i = 0; bus.digits_i = '0;
    bus.blank_i = '0; bus.lz_i = 0; bus.blink_i = '0;
    bus_al.en_i = 0; bus_al.load_i = 0; bus_al.digits_i = '0;
    bus_al.blank_i = '0; bus_al.lz_i = 0; bus_al.blink_i = '0;

    tick();
    tick();
    check("rst seg", {25'd0, bus.seg_o}, 32'h00);
    check("rst an", {28'd0, bus.an_o}, 32'h0);
    check("rst pending", {31'd0, bus.pending_o}, 32'd0);
    check("rst frame", {31'd0, bus.frame_o}, 32'd0);
    check("rst al seg", {25'd0, bus_al.seg_o}, 32'h7F);
    check("rst al an", {28'd0, bus_al.an_o}, 32'hF);

    rst_n = 1'b1;
    tick();
    bus.en_i     = 1'b1;
    bus.load_i   = 1'b1;
    bus.digits_i = 16'h1234;
    tick();
    bus.load_i = 1'b0;
    check("first pending", {31'd0, bus.pending_o}, 32'd1);
    check("first an", {28'd0, bus.an_o}, 32'h1);
    check("reset code blank", {25'd0, bus.seg_o}, {25'd0, BL});
    check("al disabled seg", {25'd0, bus_al.seg_o}, 32'h7F);
    check("al disabled an", {28'd0, bus_al.an_o}, 32'hF);
    tick();
    check("pending held", {31'd0, bus.pending_o}, 32'd1);

    sync_frame("scan");
    check("pending cleared", {31'd0, bus.pending_o}, 32'd0);
    run_frame("scan", G4, G3, G2, G1, -1, 16'h0, -1, 16'h0);

    bus.lz_i = 1'b1;
    run_frame("lz old", G4, G3, G2, G1, 0, 16'h0070, -1, 16'h0);
    run_frame("lz", G0, G7, BL, BL, -1, 16'h0, -1, 16'h0);
    bus.lz_i = 1'b0;
    run_frame("no lz", G0, G7, G0, G0, -1, 16'h0, -1, 16'h0);

    run_frame("tear", G0, G7, G0, G0, 5, 16'h5555, 15, 16'h6666);
    check("boundary load pending", {31'd0, bus.pending_o}, 32'd1);
    bus.blank_i = 4'b0010;
    run_frame("fives", G5, BL, G5, G5, -1, 16'h0, -1, 16'h0);
    bus.blank_i = 4'b0000;
    check("pending after sixes", {31'd0, bus.pending_o}, 32'd0);
    run_frame("sixes", G6, G6, G6, G6, -1, 16'h0, -1, 16'h0);

    for (int i = 0; i < 9; i++) tick();
    check("pre-disable an", {28'd0, bus.an_o}, 32'h4);
    bus.en_i = 1'b0;
    tick();
    check("disable seg", {25'd0, bus.seg_o}, 32'h00);
    check("disable an", {28'd0, bus.an_o}, 32'h0);
    check("disable frame", {31'd0, bus.frame_o}, 32'd0);
    bus.load_i   = 1'b1;
    bus.digits_i = 16'h0009;
    tick();
    bus.load_i = 1'b0;
    check("disabled load pending", {31'd0, bus.pending_o}, 32'd1);
    check("disabled an stays off", {28'd0, bus.an_o}, 32'h0);
    bus.en_i = 1'b1;
    tick();
    check("reenable an", {28'd0, bus.an_o}, 32'h1);
    check("reenable seg old", {25'd0, bus.seg_o}, {25'd0, G6});
    for (int i = 0; i < 3; i++) tick();
    check("reenable an held", {28'd0, bus.an_o}, 32'h1);
    tick();
    check("reenable an next", {28'd0, bus.an_o}, 32'h2);
    sync_frame("reenable");
    check("reenable transfer", {31'd0, bus.pending_o}, 32'd0);
    run_frame("nine", G9, G0, G0, G0, -1, 16'h0, -1, 16'h0);

    bus.load_i   = 1'b1;
    bus.digits_i = 16'h1111;
    tick();
    bus.load_i = 1'b0;
    tick();
    check("pre-reset seg", {25'd0, bus.seg_o}, {25'd0, G9});
    check("pre-reset pending", {31'd0, bus.pending_o}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("async rst seg", {25'd0, bus.seg_o}, 32'h00);
    check("async rst an", {28'd0, bus.an_o}, 32'h0);
    check("async rst pending", {31'd0, bus.pending_o}, 32'd0);

`ifdef SEVENSEG_BLINK_EN
    tick();
    rst_n        = 1'b1;
    bus.blink_i  = 4'b0001;
    bus.load_i   = 1'b1;
    bus.digits_i = 16'h1234;
    tick();
    bus.load_i = 1'b0;
    sync_frame("blink");
    run_frame("blink f1", G4, G3, G2, G1, -1, 16'h0, -1, 16'h0);
    run_frame("blink f2", BL, G3, G2, G1, -1, 16'h0, -1, 16'h0);
    run_frame("blink f3", BL, G3, G2, G1, -1, 16'h0, -1, 16'h0);
    run_frame("blink f4", G4, G3, G2, G1, -1, 16'h0, -1, 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sevenseg_scan_driver
`default_nettype wire
